// File: rtl/status_display_mux.sv
// Front-panel status display: captures NCHAN status words on their strobes, keeps
// per-channel sticky flags and scans the selected word onto a multiplexed hex display.
module status_display_mux #(
  parameter int unsigned NCHAN   = 4,
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned SELW    = 2,
  parameter int unsigned REFRESH = 50000
) (
  input  logic                      sysclk_buf,
  input  logic                      reset,
  input  logic [NCHAN*4*DIGITS-1:0] chan_data,
  input  logic [NCHAN-1:0]          chan_strobe,
  input  logic [SELW-1:0]           chan_sel,
  input  logic                      freeze,
  input  logic                      clr_sticky,
  input  logic [DIGITS-1:0]         dots_in,
  output logic [7:0]                sevenseg,
  output logic [DIGITS-1:0]         sevenseg_an,
  output logic [NCHAN-1:0]          sticky
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH - 1);
  localparam logic [DW-1:0] DIGIT_MAX = DW'(DIGITS - 1);

  logic [CW-1:0] cap [NCHAN];
  logic [PW-1:0] presc;
  logic [DW-1:0] digit;

  logic [CW-1:0] word_c;
  logic          sel_ok_c;
  logic [3:0]    nib_c;
  logic          dot_c;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Capture and sticky flags; a strobe beats a simultaneous clear.
  always_ff @(posedge sysclk_buf) begin
    if (reset) begin
      for (int c = 0; c < int'(NCHAN); c++) cap[c] <= '0;
      sticky <= '0;
    end else begin
      for (int c = 0; c < int'(NCHAN); c++)
        if (chan_strobe[c] && !freeze) cap[c] <= chan_data[c*CW +: CW];
      sticky <= (clr_sticky ? '0 : sticky) | chan_strobe;
    end
  end

  // Refresh prescaler and digit scan index.
  always_ff @(posedge sysclk_buf) begin
    if (reset) begin
      presc <= '0;
      digit <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      digit <= (digit == DIGIT_MAX) ? '0 : digit + DW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Pick the selected word, then the nibble and dot of the current digit.
  always_comb begin
    word_c   = '0;
    sel_ok_c = 1'b0;
    for (int c = 0; c < int'(NCHAN); c++)
      if (chan_sel == SELW'(c)) begin
        word_c   = cap[c];
        sel_ok_c = 1'b1;
      end
    nib_c = '0;
    dot_c = 1'b0;
    for (int d = 0; d < int'(DIGITS); d++)
      if (digit == DW'(d)) begin
        nib_c = word_c[4*d +: 4];
        dot_c = dots_in[d];
      end
  end

  always_ff @(posedge sysclk_buf) begin
    if (reset) begin
      sevenseg    <= 8'hFF;
      sevenseg_an <= '1;
    end else begin
      sevenseg_an <= ~(DIGITS'(1) << digit);
      sevenseg    <= sel_ok_c ? {~dot_c, hex7(nib_c)} : 8'hFF;
    end
  end

endmodule
